// File: rtl/fft_frame_packer.sv
// PCM sample buffer feeding an FFT core: int16 -> IEEE-754 single, packed as complex {Im=0, Re}, framed with tlast.
// Optional build macro ZERO_PAD_EN: each frame is FRAME_LEN/2 samples followed by FRAME_LEN/2 zero words.
module fft_frame_packer #(
    parameter int          FRAME_LEN  = 128,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] CFG_WORD   = 16'h0003
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] pcm_tdata,
    input  logic        pcm_tvalid,
    output logic        pcm_tready,
    output logic [15:0] m_axis_config_tdata,
    output logic        m_axis_config_tvalid,
    input  logic        m_axis_config_tready,
    output logic [63:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready,
    output logic        m_axis_data_tlast,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef ZERO_PAD_EN
    localparam logic [CNT_W-1:0] HALF_LAST_IDX = CNT_W'(FRAME_LEN / 2 - 1);
`endif

    typedef enum logic [1:0] {
        ST_CFG = 2'd0,
        ST_RUN = 2'd1,
        ST_PAD = 2'd2
    } state_t;

    // Exact int16 -> float: every 16-bit magnitude fits in the 24-bit significand.
    function automatic logic [31:0] int16_to_float(input logic [15:0] x);
        logic [15:0] mag;
        logic [3:0]  msb;
        logic [23:0] aligned;
        logic [7:0]  expo;
        mag = x[15] ? (~x + 16'd1) : x;
        msb = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) msb = 4'(i);
        end
        aligned = {8'h00, mag} << (5'd23 - {1'b0, msb});
        expo    = 8'd127 + {4'h0, msb};
        return (mag == 16'd0) ? 32'h0 : {x[15], expo, aligned[22:0]};
    endfunction

    state_t            state_q;
    logic              ready_en_q;
    logic [15:0]       cfg_tdata_q;
    logic              cfg_tvalid_q;
    logic [63:0]       data_tdata_q;
    logic              data_tvalid_q;
    logic              data_tlast_q;
    logic              frame_done_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              out_free;
    logic              data_hs;
    logic [CNT_W-1:0]  load_idx;
    logic [31:0]       head_float;

    assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pcm_tready = ready_en_q & ~fifo_full;
    assign fifo_push  = pcm_tvalid & pcm_tready;
    assign out_free   = ~data_tvalid_q | m_axis_data_tready;
    assign data_hs    = data_tvalid_q & m_axis_data_tready;
    assign fifo_pop   = (state_q == ST_RUN) & out_free & ~fifo_empty;
    assign head_float = int16_to_float(mem[rd_ptr_q]);

    // Index of the word about to be loaded: the current word (if any) is leaving on this edge.
    assign load_idx = data_tvalid_q ? (word_cnt_q + 1'b1) : word_cnt_q;

    // NOTE: sample storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge aclk) begin
        if (fifo_push) mem[wr_ptr_q] <= pcm_tdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_CFG;
            ready_en_q    <= 1'b0;
            cfg_tdata_q   <= '0;
            cfg_tvalid_q  <= 1'b0;
            data_tdata_q  <= '0;
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            cfg_tdata_q  <= CFG_WORD;
            frame_done_q <= data_hs & data_tlast_q;
            if (data_hs) word_cnt_q <= word_cnt_q + 1'b1;

            case (state_q)
                ST_CFG: begin
                    if (cfg_tvalid_q && m_axis_config_tready) begin
                        cfg_tvalid_q <= 1'b0;
                        state_q      <= ST_RUN;
                    end else begin
                        cfg_tvalid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fifo_pop) begin
                        data_tdata_q  <= {32'h0, head_float};
                        data_tvalid_q <= 1'b1;
                        data_tlast_q  <= (load_idx == LAST_IDX);
`ifdef ZERO_PAD_EN
                        if (load_idx == HALF_LAST_IDX) state_q <= ST_PAD;
`endif
                    end else if (m_axis_data_tready) begin
                        data_tvalid_q <= 1'b0;
                        data_tlast_q  <= 1'b0;
                    end
                end
`ifdef ZERO_PAD_EN
                ST_PAD: begin
                    if (out_free) begin
                        data_tdata_q  <= '0;
                        data_tvalid_q <= 1'b1;
                        data_tlast_q  <= (load_idx == LAST_IDX);
                        if (load_idx == LAST_IDX) state_q <= ST_RUN;
                    end
                end
`endif
                default: state_q <= ST_CFG;
            endcase
        end
    end

    assign m_axis_config_tdata  = cfg_tdata_q;
    assign m_axis_config_tvalid = cfg_tvalid_q;
    assign m_axis_data_tdata    = data_tdata_q;
    assign m_axis_data_tvalid   = data_tvalid_q;
    assign m_axis_data_tlast    = data_tlast_q;
    assign frame_done           = frame_done_q;

endmodule
